// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending scoreboard, two combinational read ports and issue handshake.
// Optional same-cycle write-back bypass on the read ports: define REGFILE_SCOREBOARD_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_dst,
  output logic              iss_ready,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] rs_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic              rs_ready,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rt_data,
  output logic              rt_ready,
  output logic [ADDR_W:0]   pend_cnt,
  output logic              wb_orphan
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_reg [NREG];
  logic [NREG-1:0]   pend_reg;
  logic [NREG-1:0]   pend_next;
  logic [ADDR_W:0]   cnt_reg;
  logic [ADDR_W:0]   cnt_next;
  logic              orphan_reg;

  logic wb_hit;
  logic iss_acc;
  logic cnt_inc;
  logic cnt_dec;

  assign wb_hit    = wb_valid & (wb_dst != '0);
  // A write-back landing this cycle frees the register, so a WAW issue may proceed.
  assign iss_ready = (iss_dst == '0) | ~pend_reg[iss_dst] | (wb_valid & (wb_dst == iss_dst));
  assign iss_acc   = iss_valid & iss_ready & (iss_dst != '0);

  assign cnt_inc  = iss_acc;
  assign cnt_dec  = wb_hit & pend_reg[wb_dst];
  assign cnt_next = cnt_reg + {{ADDR_W{1'b0}}, cnt_inc} - {{ADDR_W{1'b0}}, cnt_dec};

  // Set from an accepted issue wins over the clear from a same-register write-back.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_pend
      if (gi == 0) begin : g_zero
        assign pend_next[gi] = 1'b0;
      end else begin : g_reg
        assign pend_next[gi] = (iss_acc & (iss_dst == ADDR_W'(gi)))
                             | (pend_reg[gi] & ~(wb_hit & (wb_dst == ADDR_W'(gi))));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_reg[i] <= '0;
      end
    end else if (wb_hit) begin
      regs_reg[wb_dst] <= wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg   <= '0;
      cnt_reg    <= '0;
      orphan_reg <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      cnt_reg    <= cnt_next;
      orphan_reg <= wb_hit & ~pend_reg[wb_dst];
    end
  end

  assign pend_cnt  = cnt_reg;
  assign wb_orphan = orphan_reg;

  // Read ports: index 0 is rs, index 1 is rt.
  logic [1:0][ADDR_W-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;
  logic [1:0]             rd_ready;

  assign rd_addr[0] = rs_addr;
  assign rd_addr[1] = rt_addr;

  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic              byp;
      logic              is_zero;
      logic [DATA_W-1:0] arr_data;
`ifdef REGFILE_SCOREBOARD_BYPASS_EN
      // Gated by rst_n so reset forces read data to zero regardless of write-back inputs.
      assign byp = rst_n & wb_hit & (wb_dst == rd_addr[gi]);
`else
      assign byp = 1'b0;
`endif
      assign is_zero      = (rd_addr[gi] == '0);
      assign arr_data     = regs_reg[rd_addr[gi]];
      assign rd_data[gi]  = is_zero ? '0 : (byp ? wb_data : arr_data);
      assign rd_ready[gi] = is_zero | byp | ~pend_reg[rd_addr[gi]];
    end
  endgenerate

  assign rs_data  = rd_data[0];
  assign rs_ready = rd_ready[0];
  assign rt_data  = rd_data[1];
  assign rt_ready = rd_ready[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized and directed bench for regfile_scoreboard against an array-based reference model.
module tb_regfile_scoreboard;

`ifdef REGFILE_SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_dst;
  logic        iss_ready;
  logic        wb_valid;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic [4:0]  rs_addr;
  logic [31:0] rs_data;
  logic        rs_ready;
  logic [4:0]  rt_addr;
  logic [31:0] rt_data;
  logic        rt_ready;
  logic [5:0]  pend_cnt;
  logic        wb_orphan;

  regfile_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_dst(iss_dst), .iss_ready(iss_ready),
    .wb_valid(wb_valid), .wb_dst(wb_dst), .wb_data(wb_data),
    .rs_addr(rs_addr), .rs_data(rs_data), .rs_ready(rs_ready),
    .rt_addr(rt_addr), .rt_data(rt_data), .rt_ready(rt_ready),
    .pend_cnt(pend_cnt), .wb_orphan(wb_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];
  bit          m_orphan;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    m_orphan = 1'b0;
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_pend[i] ? 1 : 0;
    return n;
  endfunction

  function automatic bit wb_targets(input logic [4:0] a);
    return wb_valid && (wb_dst != 5'd0) && (wb_dst == a);
  endfunction

  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYP && wb_targets(a)) return wb_data;
    return m_regs[a];
  endfunction

  function automatic logic exp_rdy(input logic [4:0] a);
    if (a == 5'd0) return 1'b1;
    if (BYP && wb_targets(a)) return 1'b1;
    return !m_pend[a];
  endfunction

  function automatic logic exp_iss_ready();
    return (iss_dst == 5'd0) || !m_pend[iss_dst] || (wb_valid && wb_dst == iss_dst);
  endfunction

  // One transaction per clock: entered and left at posedge+1.
  task automatic step(input logic iv, input logic [4:0] id, input logic wv, input logic [4:0] wd,
                      input logic [31:0] wdat, input logic [4:0] ra, input logic [4:0] rb);
    logic acc;
    iss_valid = iv; iss_dst = id; wb_valid = wv; wb_dst = wd; wb_data = wdat;
    rs_addr = ra; rt_addr = rb;
    @(negedge clk);
    check("iss_ready", {31'h0, iss_ready}, {31'h0, exp_iss_ready()});
    check("rs_data", rs_data, exp_data(ra));
    check("rs_ready", {31'h0, rs_ready}, {31'h0, exp_rdy(ra)});
    check("rt_data", rt_data, exp_data(rb));
    check("rt_ready", {31'h0, rt_ready}, {31'h0, exp_rdy(rb)});
    acc = iv && exp_iss_ready();
    @(posedge clk);
    if (wv && wd != 5'd0) begin
      m_orphan   = !m_pend[wd];
      m_regs[wd] = wdat;
      m_pend[wd] = 1'b0;
    end else begin
      m_orphan = 1'b0;
    end
    if (acc && id != 5'd0) m_pend[id] = 1'b1;
    #1;
    check("pend_cnt", {26'h0, pend_cnt}, 32'(m_count()));
    check("wb_orphan", {31'h0, wb_orphan}, {31'h0, m_orphan});
    $display("txn iss=%0b/%0d wb=%0b/%0d data=%h rs=%0d rt=%0d cnt=%0d", iv, id, wv, wd, wdat, ra, rb, pend_cnt);
  endtask

  task automatic idle(input logic [4:0] ra, input logic [4:0] rb);
    step(1'b0, 5'd0, 1'b0, 5'd0, 32'h0, ra, rb);
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_dst = '0; wb_valid = 1'b0; wb_dst = '0; wb_data = '0;
    rs_addr = 5'd8; rt_addr = 5'd31;
    model_reset();
    #12;
    check("rst_rs_data", rs_data, 32'h0);
    check("rst_rs_ready", {31'h0, rs_ready}, 32'h1);
    check("rst_rt_ready", {31'h0, rt_ready}, 32'h1);
    check("rst_iss_ready", {31'h0, iss_ready}, 32'h1);
    check("rst_pend_cnt", {26'h0, pend_cnt}, 32'h0);
    check("rst_orphan", {31'h0, wb_orphan}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Every address reads zero and ready after reset.
    for (int a = 0; a < 32; a++) idle(5'(a), 5'(31 - a));

    // RAW on register 8.
    step(1'b1, 5'd8, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0);
    idle(5'd8, 5'd8);
    step(1'b0, 5'd0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8);
    idle(5'd8, 5'd8);

    // WAW on register 5.
    step(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    step(1'b1, 5'd5, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    step(1'b1, 5'd5, 1'b1, 5'd5, 32'h0000_0A05, 5'd5, 5'd5);
    step(1'b0, 5'd0, 1'b1, 5'd5, 32'h0000_0B05, 5'd5, 5'd5);

    // Register 0 issue and write are no-ops.
    step(1'b1, 5'd0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Orphan write-back.
    step(1'b0, 5'd0, 1'b1, 5'd3, 32'h55, 5'd0, 5'd3);
    idle(5'd0, 5'd3);
    idle(5'd0, 5'd3);

    // Fill all registers, then drain in reverse.
    for (int r = 1; r < 32; r++) step(1'b1, 5'(r), 1'b0, 5'd0, 32'h0, 5'(r), 5'd0);
    for (int r = 31; r >= 1; r--) step(1'b0, 5'd0, 1'b1, 5'(r), $urandom, 5'(r), 5'(r));
    for (int r = 1; r < 32; r++) idle(5'(r), 5'(32 - r));

    // Asynchronous reset mid-cycle.
    step(1'b1, 5'd9, 1'b0, 5'd0, 32'h0, 5'd9, 5'd12);
    step(1'b1, 5'd10, 1'b0, 5'd0, 32'h0, 5'd9, 5'd12);
    iss_valid = 1'b1; iss_dst = 5'd9; rs_addr = 5'd9; rt_addr = 5'd12;
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_rs_data", rs_data, 32'h0);
    check("mid_rst_rs_ready", {31'h0, rs_ready}, 32'h1);
    check("mid_rst_rt_data", rt_data, 32'h0);
    check("mid_rst_iss_ready", {31'h0, iss_ready}, 32'h1);
    check("mid_rst_pend_cnt", {26'h0, pend_cnt}, 32'h0);
    model_reset();
    iss_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(5'd9, 5'd12);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)),
           $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
